// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // One writeback request: destination register plus result data.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LNG  = 2'd2
  } gnt_t;

  // x0 is hardwired to zero, so writes to it are suppressed.
  function automatic logic is_x0(input logic [REG_AW-1:0] rd);
    return (rd == {REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests for the long-latency path.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == {(AW + 1){1'b0}});
  // Guards keep the pointers consistent even if a caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Wrap-around pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered
// long-latency results onto the register-file write port, bounds the
// starvation of the long path and keeps a pending-destination scoreboard.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_stall,
  input  logic            lng_issue_valid,
  input  logic [4:0]      lng_issue_rd,
  input  logic            lng_valid,
  output logic            lng_ready,
  input  logic [4:0]      lng_rd,
  input  logic [XLEN-1:0] lng_wd,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     busy
);

  import wb_pkg::*;

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  wb_req_t         lng_req;
  wb_req_t         head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            ready_en;
  gnt_t            gnt;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_nxt;
  logic [31:0]     busy_nxt;
  logic            rf_we_nxt;
  logic [4:0]      rf_rd_nxt;
  logic [XLEN-1:0] rf_wd_nxt;

  assign lng_req.rd = lng_rd;
  assign lng_req.wd = lng_wd;

  // ready_en is a register so lng_ready stays low through reset without
  // a combinational path from rst_n.
  assign lng_ready = ready_en && !fifo_full;
  assign alu_stall = (starve_cnt == LIMIT);
  assign push      = lng_valid && lng_ready;
  assign pop       = (gnt == GNT_LNG);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (lng_req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Grant selection: a stalled ALU yields to the FIFO, else ALU first.
  always_comb begin
    gnt = GNT_NONE;
    if (alu_stall) begin
      if (!fifo_empty) begin
        gnt = GNT_LNG;
      end else begin
        gnt = GNT_NONE;
      end
    end else if (alu_valid) begin
      gnt = GNT_ALU;
    end else if (!fifo_empty) begin
      gnt = GNT_LNG;
    end else begin
      gnt = GNT_NONE;
    end
  end

  // Next register-file write from the granted source; x0 writes are dropped.
  always_comb begin
    rf_we_nxt = 1'b0;
    rf_rd_nxt = rf_rd;
    rf_wd_nxt = rf_wd;
    case (gnt)
      GNT_ALU: begin
        rf_we_nxt = !is_x0(alu_rd);
        rf_rd_nxt = alu_rd;
        rf_wd_nxt = alu_wd;
      end
      GNT_LNG: begin
        rf_we_nxt = !is_x0(head.rd);
        rf_rd_nxt = head.rd;
        rf_wd_nxt = head.wd;
      end
      default: begin
        rf_we_nxt = 1'b0;
        rf_rd_nxt = rf_rd;
        rf_wd_nxt = rf_wd;
      end
    endcase
  end

  // Starvation counter: counts ALU wins while the FIFO waits, saturating.
  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || fifo_empty) begin
      starve_nxt = {CW{1'b0}};
    end else if ((gnt == GNT_ALU) && (starve_cnt != LIMIT)) begin
      starve_nxt = starve_cnt + CNT_ONE;
    end else begin
      starve_nxt = starve_cnt;
    end
  end

  // Scoreboard: pops clear, issues set afterwards so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (pop && !is_x0(head.rd)) begin
      busy_nxt[head.rd] = 1'b0;
    end else begin
      busy_nxt = busy_nxt;
    end
    if (lng_issue_valid && !is_x0(lng_issue_rd)) begin
      busy_nxt[lng_issue_rd] = 1'b1;
    end else begin
      busy_nxt = busy_nxt;
    end
    busy_nxt[0] = 1'b0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_wd      <= {XLEN{1'b0}};
      busy       <= 32'd0;
      starve_cnt <= {CW{1'b0}};
      ready_en   <= 1'b0;
    end else begin
      rf_we      <= rf_we_nxt;
      rf_rd      <= rf_rd_nxt;
      rf_wd      <= rf_wd_nxt;
      busy       <= busy_nxt;
      starve_cnt <= starve_nxt;
      ready_en   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            alu_stall;
  logic            lng_issue_valid;
  logic [4:0]      lng_issue_rd;
  logic            lng_valid;
  logic            lng_ready;
  logic [4:0]      lng_rd;
  logic [XLEN-1:0] lng_wd;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [31:0]     busy;

  wb_arbiter #(
    .XLEN         (XLEN),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_valid       (alu_valid),
    .alu_rd          (alu_rd),
    .alu_wd          (alu_wd),
    .alu_stall       (alu_stall),
    .lng_issue_valid (lng_issue_valid),
    .lng_issue_rd    (lng_issue_rd),
    .lng_valid       (lng_valid),
    .lng_ready       (lng_ready),
    .lng_rd          (lng_rd),
    .lng_wd          (lng_wd),
    .rf_we           (rf_we),
    .rf_rd           (rf_rd),
    .rf_wd           (rf_wd),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO as queues, starvation as a plain integer.
  logic [4:0]  q_rd[$];
  logic [31:0] q_wd[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid       = 1'b0;
    alu_rd          = 5'd0;
    alu_wd          = 32'd0;
    lng_issue_valid = 1'b0;
    lng_issue_rd    = 5'd0;
    lng_valid       = 1'b0;
    lng_rd          = 5'd0;
    lng_wd          = 32'd0;
  endtask

  task automatic model_init();
    q_rd.delete();
    q_wd.delete();
    m_starve = 0;
    m_busy   = 32'd0;
    m_we     = 1'b0;
    m_rd     = 5'd0;
    m_wd     = 32'd0;
  endtask

  // Check current outputs against the model, advance the model by one
  // cycle using the inputs now driven, then move to the next negedge.
  task automatic step();
    int          g;
    bit          was_empty;
    bit          acc;
    logic [4:0]  p_rd;
    logic [31:0] p_wd;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk("rf_rd", 32'(rf_rd), 32'(m_rd));
      chk("rf_wd", rf_wd, m_wd);
    end
    chk("lng_ready", 32'(lng_ready), 32'(q_rd.size() < DEPTH));
    chk("alu_stall", 32'(alu_stall), 32'(m_starve == LIMIT));
    chk("busy", busy, m_busy);

    was_empty = (q_rd.size() == 0);
    if (m_starve == LIMIT) g = was_empty ? 0 : 2;
    else if (alu_valid)    g = 1;
    else if (!was_empty)   g = 2;
    else                   g = 0;
    acc  = lng_valid && (q_rd.size() < DEPTH);
    m_we = 1'b0;
    if (g == 1) begin
      m_we = (alu_rd != 5'd0);
      m_rd = alu_rd;
      m_wd = alu_wd;
    end
    if (g == 2) begin
      p_rd = q_rd.pop_front();
      p_wd = q_wd.pop_front();
      m_we = (p_rd != 5'd0);
      m_rd = p_rd;
      m_wd = p_wd;
      if (p_rd != 5'd0) m_busy[p_rd] = 1'b0;
    end
    if (lng_issue_valid && lng_issue_rd != 5'd0) m_busy[lng_issue_rd] = 1'b1;
    if (g == 2 || was_empty) m_starve = 0;
    else if (g == 1 && m_starve < LIMIT) m_starve = m_starve + 1;
    if (acc) begin
      q_rd.push_back(lng_rd);
      q_wd.push_back(lng_wd);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset with random inputs; outputs must read zero throughout.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      alu_valid       = 1'($urandom_range(0, 1));
      alu_rd          = 5'($urandom_range(0, 31));
      alu_wd          = $urandom;
      lng_issue_valid = 1'($urandom_range(0, 1));
      lng_issue_rd    = 5'($urandom_range(0, 31));
      lng_valid       = 1'($urandom_range(0, 1));
      lng_rd          = 5'($urandom_range(0, 31));
      lng_wd          = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_rd", 32'(rf_rd), 32'd0);
      chk("rst_rf_wd", rf_wd, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_alu_stall", 32'(alu_stall), 32'd0);
      chk("rst_lng_ready", 32'(lng_ready), 32'd0);
    end
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_lng_ready", 32'(lng_ready), 32'd1);
    chk("rel_busy", busy, 32'd0);
    chk("rel_rf_we", 32'(rf_we), 32'd0);
    model_init();
  endtask

  initial begin
    int k;
    bit acc;
    idle();
    model_init();
    do_reset(3);

    // ALU path, then an ALU write to x0.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEAD_BEEF;
    step();
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_rd", 32'(rf_rd), 32'd5);
    chk("alu_wd", rf_wd, 32'hDEAD_BEEF);
    alu_rd = 5'd0; alu_wd = 32'h1111_2222;
    step();
    idle();
    chk("alu_x0_we", 32'(rf_we), 32'd0);
    step();

    // Scoreboard set at issue, clear at pop.
    lng_issue_valid = 1'b1; lng_issue_rd = 5'd7;
    step();
    idle();
    chk("sb_set", 32'(busy[7]), 32'd1);
    step();
    step();
    lng_valid = 1'b1; lng_rd = 5'd7; lng_wd = 32'h0000_1234;
    step();
    idle();
    chk("sb_held", 32'(busy[7]), 32'd1);
    step();
    chk("sb_pop_we", 32'(rf_we), 32'd1);
    chk("sb_pop_rd", 32'(rf_rd), 32'd7);
    chk("sb_pop_wd", rf_wd, 32'h0000_1234);
    chk("sb_clear", 32'(busy[7]), 32'd0);

    // Full FIFO backpressure under continuous ALU traffic.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h0000_0A1A;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (k < 3) begin
        lng_valid = 1'b1;
        lng_rd    = 5'(20 + k);
        lng_wd    = 32'hB000_0000 + 32'(k);
      end else begin
        lng_valid = 1'b0;
      end
      if (c < 2) chk("bp_ready_open", 32'(lng_ready), 32'd1);
      if (c >= 2 && c <= 5) chk("bp_ready_full", 32'(lng_ready), 32'd0);
      acc = lng_valid && (q_rd.size() < DEPTH);
      step();
      if (acc) k++;
    end
    chk("bp_all_taken", 32'(k), 32'd3);
    idle();
    for (int c = 0; c < 4; c++) step();

    // Starvation bound: one queued result against continuous ALU traffic.
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h0000_0044;
    lng_valid = 1'b1; lng_rd = 5'd11; lng_wd = 32'hCAFE_0011;
    step();
    lng_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("st_no_stall", 32'(alu_stall), 32'd0);
      step();
      chk("st_alu_won", 32'(rf_rd), 32'd4);
    end
    chk("st_stall", 32'(alu_stall), 32'd1);
    step();
    chk("st_lng_we", 32'(rf_we), 32'd1);
    chk("st_lng_rd", 32'(rf_rd), 32'd11);
    chk("st_lng_wd", rf_wd, 32'hCAFE_0011);
    chk("st_cleared", 32'(alu_stall), 32'd0);
    idle();
    step();

    // Same-cycle set and clear of x9: set wins, a later pop clears.
    lng_issue_valid = 1'b1; lng_issue_rd = 5'd9;
    step();
    idle();
    lng_valid = 1'b1; lng_rd = 5'd9; lng_wd = 32'h0000_9A9A;
    step();
    idle();
    lng_issue_valid = 1'b1; lng_issue_rd = 5'd9;
    step();
    idle();
    chk("sc_pop_rd", 32'(rf_rd), 32'd9);
    chk("sc_set_wins", 32'(busy[9]), 32'd1);
    lng_valid = 1'b1; lng_rd = 5'd9; lng_wd = 32'h0000_9B9B;
    step();
    idle();
    step();
    chk("sc_pop2_wd", rf_wd, 32'h0000_9B9B);
    chk("sc_cleared", 32'(busy[9]), 32'd0);

    // Randomized traffic honouring the hold rules, with a mid-run reset.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset(2);
      if (m_starve != LIMIT) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_wd    = $urandom;
      end
      if (!(lng_valid && q_rd.size() >= DEPTH)) begin
        lng_valid = ($urandom_range(0, 9) < 5);
        lng_rd    = 5'($urandom_range(0, 31));
        lng_wd    = $urandom;
      end
      lng_issue_valid = ($urandom_range(0, 9) < 3);
      lng_issue_rd    = 5'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
